// File: rtl/switch_pkg.sv
// Shared definitions for the switch bank: register offsets, hardware version
// and the debounce FSM state encoding.
package switch_pkg;

    localparam logic [31:0] HW_VER      = 32'h0000_0002;

    localparam logic [31:0] ADDR_VER    = 32'h0000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;
    localparam logic [31:0] ADDR_RAW    = 32'h0000_0008;
    localparam logic [31:0] ADDR_EDGE   = 32'h0000_000C;
    localparam logic [31:0] ADDR_IRQ_EN = 32'h0000_0010;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_t;

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: 2-flop synchroniser followed by a debounce FSM.
// o_upd pulses (from registered state only) in the cycle whose clock edge
// loads the new debounced level, so the parent can flag the change in step.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_pin,
    output logic o_raw,
    output logic o_level,
    output logic o_upd
);

    localparam int            CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    db_state_t     r_state;

    logic          w_diff;
    logic          w_done;

    // The counter holds the number of consecutive differing cycles already
    // seen, so the level flips on the DB_CYCLES-th one (STABLE has count 0,
    // which makes DB_CYCLES=1 flip on the first differing cycle).
    assign w_diff  = (r_sync2 != r_level);
    assign w_done  = w_diff && (r_cnt == CNT_LAST);
    assign o_raw   = r_sync2;
    assign o_level = r_level;
    assign o_upd   = w_done;

    // Two-flop synchroniser for the asynchronous pin level.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM: count persistence of a differing level, reject glitches.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= DB_STABLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            case (r_state)
                DB_STABLE: begin
                    if (w_done) begin
                        r_level <= r_sync2;
                        r_cnt   <= '0;
                    end else if (w_diff) begin
                        r_state <= DB_COUNTING;
                        r_cnt   <= r_cnt + CW'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                DB_COUNTING: begin
                    if (!w_diff) begin
                        r_state <= DB_STABLE;
                        r_cnt   <= '0;
                    end else if (w_done) begin
                        r_level <= r_sync2;
                        r_state <= DB_STABLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= DB_STABLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_bank.sv
// Debounced switch bank with a small CPU register interface.
// Optional feature macro: SWITCH_BANK_IRQ_EN enables the EDGE / IRQ_EN
// registers and the irq output; without it both registers read 0 and irq is 0.
module switch_bank
    import switch_pkg::*;
#(
    parameter int N_SW      = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            rd,
    input  logic [31:0]     raddr,
    output logic [31:0]     rdata,
    input  logic            wr,
    input  logic [31:0]     waddr,
    input  logic [31:0]     wdata,
    input  logic [N_SW-1:0] switch_pin,
    output logic            irq
);

    logic [N_SW-1:0] w_raw;
    logic [N_SW-1:0] w_level;
    logic [N_SW-1:0] w_upd;
    logic [N_SW-1:0] w_edge;
    logic [N_SW-1:0] w_irq_en;
    logic [31:0]     w_rd_mux;
    logic [31:0]     w_status32;
    logic [31:0]     w_raw32;
    logic [31:0]     w_edge32;
    logic [31:0]     w_irq_en32;
    logic [31:0]     r_rdata;
    logic            w_unused_ok;

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_ch
        switch_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .i_clk   (clk),
            .i_rstn  (rstn),
            .i_pin   (switch_pin[gi]),
            .o_raw   (w_raw[gi]),
            .o_level (w_level[gi]),
            .o_upd   (w_upd[gi])
        );
    end

    // Inputs that go unread in the build without the interrupt feature.
    assign w_unused_ok = ^{wr, waddr, wdata, w_upd};

`ifdef SWITCH_BANK_IRQ_EN
    logic [N_SW-1:0] r_edge;
    logic [N_SW-1:0] r_irq_en;
    logic            r_irq;
    logic [N_SW-1:0] w_edge_clr;
    logic [N_SW-1:0] w_edge_nxt;
    logic [N_SW-1:0] w_irq_en_nxt;

    // Next-state of EDGE and IRQ_EN; a new edge wins over a same-cycle clear.
    always_comb begin
        w_edge_clr   = '0;
        w_irq_en_nxt = r_irq_en;
        if (wr && (waddr == ADDR_EDGE)) begin
            w_edge_clr = wdata[N_SW-1:0];
        end else begin
            w_edge_clr = '0;
        end
        if (wr && (waddr == ADDR_IRQ_EN)) begin
            w_irq_en_nxt = wdata[N_SW-1:0];
        end else begin
            w_irq_en_nxt = r_irq_en;
        end
        w_edge_nxt = (r_edge & ~w_edge_clr) | w_upd;
    end

    // EDGE / IRQ_EN state and a registered irq that tracks them cycle for cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_edge   <= '0;
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_edge   <= w_edge_nxt;
            r_irq_en <= w_irq_en_nxt;
            r_irq    <= |(w_edge_nxt & w_irq_en_nxt);
        end
    end

    assign w_edge   = r_edge;
    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_edge   = '0;
    assign w_irq_en = '0;
    assign irq      = 1'b0;
`endif

    // Zero-extend the channel vectors and select the addressed register.
    always_comb begin
        w_status32             = '0;
        w_raw32                = '0;
        w_edge32               = '0;
        w_irq_en32             = '0;
        w_status32[N_SW-1:0]   = w_level;
        w_raw32[N_SW-1:0]      = w_raw;
        w_edge32[N_SW-1:0]     = w_edge;
        w_irq_en32[N_SW-1:0]   = w_irq_en;
        case (raddr)
            ADDR_VER:    w_rd_mux = HW_VER;
            ADDR_STATUS: w_rd_mux = w_status32;
            ADDR_RAW:    w_rd_mux = w_raw32;
            ADDR_EDGE:   w_rd_mux = w_edge32;
            ADDR_IRQ_EN: w_rd_mux = w_irq_en32;
            default:     w_rd_mux = 32'h0000_0000;
        endcase
    end

    // Read data register: loads on rd (pre-write values), otherwise holds.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rdata <= 32'h0000_0000;
        end else if (rd) begin
            r_rdata <= w_rd_mux;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign rdata = r_rdata;

endmodule

// File: doc/switch_bank.md
SWITCH_BANK -- requirements
Module: switch_bank

Interface
REQ-001 Parameter N_SW, default 4, number of switch channels (legal 1..32).
REQ-002 Parameter DB_CYCLES, default 16, debounce stability count in clk cycles (legal 1..65535).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 rd  input  1  CPU read strobe, one cycle per access.
REQ-006 raddr  input  32  CPU read byte address.
REQ-007 rdata  output  32  registered read data.
REQ-008 wr  input  1  CPU write strobe, one cycle per access.
REQ-009 waddr  input  32  CPU write byte address.
REQ-010 wdata  input  32  CPU write data.
REQ-011 switch_pin  input  N_SW  asynchronous raw switch levels.
REQ-012 irq  output  1  level interrupt, active-high.

Function
REQ-013 Register map: 0x00 VER (RO, 32'h02), 0x04 STATUS (RO, debounced levels), 0x08 RAW (RO, synchronised undebounced levels), 0x0C EDGE (RW1C, sticky change flags), 0x10 IRQ_EN (RW, per-channel mask).
REQ-014 Registers narrower than 32 bits: upper bits read 0.
REQ-015 Read latency exactly one cycle: rdata updates on the clk edge where rd=1; rdata holds its last value while rd=0.
REQ-016 Unmapped read address: rdata loads 0; unmapped or RO write: no effect.
REQ-017 Each switch_pin bit passes through a 2-flop synchroniser before any use; RAW reflects the second flop.
REQ-018 Per-channel debounce FSM, states STABLE and COUNTING; STABLE->COUNTING when sync level != debounced level; counter increments each cycle in COUNTING.
REQ-019 COUNTING->STABLE with counter cleared when sync level returns to debounced level (glitch rejected, STATUS unchanged).
REQ-020 Debounced level takes the sync level when the differing level has persisted DB_CYCLES consecutive cycles; FSM returns to STABLE, counter cleared.
REQ-021 Pin-to-STATUS latency for a clean step = 2 (sync) + DB_CYCLES cycles; counter width = clog2(DB_CYCLES+1), no wrap possible.
REQ-022 Any change of a debounced bit (rise or fall) sets the matching EDGE bit in the same cycle STATUS updates.
REQ-023 Write to EDGE clears bits where wdata=1; a set and a clear on the same bit in the same cycle: set wins.
REQ-024 Simultaneous rd and wr to the same register: rdata returns the pre-write value.
REQ-025 irq = |(EDGE & IRQ_EN), driven from registers, no combinational path from CPU inputs.

Reset
REQ-026 On rstn=0 at a clk edge: rdata=0, irq=0, synchronisers=0, STATUS=0, all FSMs STABLE with counter 0, EDGE=0, IRQ_EN=0.
REQ-027 Reset mid-debounce discards the count; a pin held high through reset reaches STATUS 2+DB_CYCLES cycles after rstn rises and sets EDGE.
REQ-028 rd/wr during reset are ignored.

Configuration
REQ-029 Macro SWITCH_BANK_IRQ_EN defined: EDGE, IRQ_EN and irq behave as above.
REQ-030 Macro undefined: EDGE and IRQ_EN logic absent, both read 0, writes ignored, irq tied 0; VER, STATUS, RAW and debounce unchanged.

Structure
REQ-031 Shared package switch_pkg holds register offsets, HW_VER value and the debounce FSM state encoding.
REQ-032 One sub-module switch_debounce (synchroniser + FSM + counter for one channel), instantiated N_SW times by generate loop.

Verification
REQ-033 Reset then read 0x00 -> rdata=32'h02 one cycle after rd; read 0x14 -> rdata=0.
REQ-034 N_SW=4, DB_CYCLES=16, pin[2] 0->1 held -> STATUS=4'b0100 exactly 18 cycles after the change; EDGE=4'b0100.
REQ-035 pin[0] pulse 10 cycles wide with DB_CYCLES=16 -> STATUS and EDGE unchanged, RAW shows pulse delayed 2 cycles.
REQ-036 IRQ_EN=4'b0100, edge on ch2 -> irq=1; write EDGE=4'b0100 -> irq=0 next cycle; new edge on clear cycle -> EDGE bit stays 1.
REQ-037 rstn=0 mid-count on ch1 then release with pin high -> STATUS[1]=1 at 18 cycles after release, never earlier.
REQ-038 Build without SWITCH_BANK_IRQ_EN, toggle pins, write 0xF to 0x10 -> reads of 0x0C/0x10 return 0, irq stays 0.
